// File: rtl/wb_rr_arbiter.sv
// wb_rr_arbiter: round-robin arbiter that lets N Wishbone classic masters share one slave.
//
// A master is granted for a whole CYC (bus lock), so it can issue back-to-back STB beats.
// Every release is followed by one ARB_RELEASE cycle with the slave port idle. This lets the
// downstream slave FSM return to idle before the next owner starts.
//
// Optional feature (macro WB_ARB_TIMEOUT_EN): a stall counter raises a bus error. After
// TIMEOUT_CYCLES stalled beat cycles without ACK, the owner gets a one-cycle m_err_o pulse and
// loses the bus. When the macro is undefined, m_err_o is tied low and no counter is built.
//
// Ports:
//   clock, reset        system clock; synchronous active-high reset
//   m_cyc_i/m_stb_i/m_we_i   per-master Wishbone controls (N bits)
//   m_adr_i/m_dat_i/m_sel_i  per-master address/data/select, master i at [i*W +: W]
//   m_dat_o             read data broadcast to all masters (= s_dat_i)
//   m_ack_o/m_err_o     per-master ACK / bus error
//   s_*_o               single master port towards the slave
//   s_dat_i, s_ack_i    slave read data / ACK
//   grant_o             registered one-hot grant, zero when there is no owner
//   state_o             arbiter state for debug (0 idle, 1 busy, 2 release)
module wb_rr_arbiter #(
  parameter int unsigned N              = 4,
  parameter int unsigned AW             = 32,
  parameter int unsigned DW             = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N-1:0]         m_cyc_i,
  input  logic [N-1:0]         m_stb_i,
  input  logic [N-1:0]         m_we_i,
  input  logic [N*AW-1:0]      m_adr_i,
  input  logic [N*DW-1:0]      m_dat_i,
  input  logic [N*(DW/8)-1:0]  m_sel_i,
  output logic [DW-1:0]        m_dat_o,
  output logic [N-1:0]         m_ack_o,
  output logic [N-1:0]         m_err_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  output logic [(DW/8)-1:0]    s_sel_o,
  input  logic [DW-1:0]        s_dat_i,
  input  logic                 s_ack_i,
  output logic [N-1:0]         grant_o,
  output logic [1:0]           state_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ArbIdle    = 2'd0,
    ArbBusy    = 2'd1,
    ArbRelease = 2'd2
  } arb_state_e;

  arb_state_e    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [PW-1:0] owner_next;
  logic [PW-1:0] scan_idx;
  logic [PW-1:0] pick_idx;
  logic          pick_found;
  logic          timeout_hit;
  logic          busy;

  assign busy    = (state_q == ArbBusy);
  assign grant_o = grant_q;
  assign state_o = state_q;
  assign m_dat_o = s_dat_i;

  assign owner_next = (owner_q == PW'(N - 1)) ? '0 : owner_q + 1'b1;

  // First requester found scanning ptr, ptr+1, ... modulo N.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 0; k < int'(N); k++) begin
      scan_idx = PW'((int'(ptr_q) + k) % int'(N));
      if (!pick_found && m_cyc_i[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    case (state_q)
      ArbIdle: begin
        if (pick_found) begin
          state_d           = ArbBusy;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
        end
      end
      ArbBusy: begin
        // Owner is never preempted by other requests; only its own CYC drop or a timeout ends it.
        if (!m_cyc_i[owner_q] || timeout_hit) begin
          state_d = ArbRelease;
          grant_d = '0;
          ptr_d   = owner_next;
        end
      end
      ArbRelease: begin
        state_d = ArbIdle;
      end
      default: begin
        state_d = ArbIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ArbIdle;
      grant_q <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Slave port mux. Reset gates the handshake outputs so a reset cycle never emits ACK or CYC.
  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    m_ack_o = '0;
    if (busy) begin
      s_we_o  = m_we_i[owner_q];
      s_adr_o = m_adr_i[owner_q*AW +: AW];
      s_dat_o = m_dat_i[owner_q*DW +: DW];
      s_sel_o = m_sel_i[owner_q*SW +: SW];
      if (!reset) begin
        s_cyc_o          = m_cyc_i[owner_q] & ~timeout_hit;
        s_stb_o          = m_cyc_i[owner_q] & m_stb_i[owner_q] & ~timeout_hit;
        // A spurious ACK with no beat in flight is dropped here.
        m_ack_o[owner_q] = s_ack_i & s_stb_o;
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] tmo_cnt_q;

  assign timeout_hit = busy && (tmo_cnt_q == CntW'(TIMEOUT_CYCLES));
  assign m_err_o     = (timeout_hit && !reset) ? grant_q : '0;

  // Counts stalled beat cycles; cleared on a real ACK and whenever the bus is not held next cycle.
  always_ff @(posedge clock) begin
    if (reset || (state_d != ArbBusy) || (s_stb_o && s_ack_i)) begin
      tmo_cnt_q <= '0;
    end else if (s_stb_o && !s_ack_i) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign m_err_o            = '0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_wb_rr_arbiter.sv
module tb_wb_rr_arbiter;
  localparam int unsigned N   = 4;
  localparam int unsigned AW  = 32;
  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = DW / 8;
  localparam int unsigned TMO = 8;
  localparam int unsigned T2_START = 6;
  localparam int unsigned NVEC = 23;

  logic              clock = 1'b0;
  logic              reset;
  logic [N-1:0]      m_cyc_i, m_stb_i, m_we_i;
  logic [N*AW-1:0]   m_adr_i;
  logic [N*DW-1:0]   m_dat_i;
  logic [N*SW-1:0]   m_sel_i;
  logic [DW-1:0]     m_dat_o;
  logic [N-1:0]      m_ack_o, m_err_o;
  logic              s_cyc_o, s_stb_o, s_we_o;
  logic [AW-1:0]     s_adr_o;
  logic [DW-1:0]     s_dat_o;
  logic [SW-1:0]     s_sel_o;
  logic [DW-1:0]     s_dat_i;
  logic              s_ack_i;
  logic [N-1:0]      grant_o;
  logic [1:0]        state_o;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clock = ~clock;

  wb_rr_arbiter #(
    .N              (N),
    .AW             (AW),
    .DW             (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .m_cyc_i (m_cyc_i),
    .m_stb_i (m_stb_i),
    .m_we_i  (m_we_i),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_sel_i (m_sel_i),
    .m_dat_o (m_dat_o),
    .m_ack_o (m_ack_o),
    .m_err_o (m_err_o),
    .s_cyc_o (s_cyc_o),
    .s_stb_o (s_stb_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_sel_o (s_sel_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .grant_o (grant_o),
    .state_o (state_o)
  );

  typedef struct {
    logic [3:0] cyc;
    logic       ack;
    logic [1:0] st;
    logic [3:0] gnt;
    logic       scyc;
    logic [3:0] mack;
  } vec_t;

  vec_t vt [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    m_cyc_i = '0;
    m_stb_i = '0;
    m_we_i  = '0;
    m_adr_i = '0;
    m_dat_i = '0;
    m_sel_i = '0;
    s_ack_i = 1'b0;
    s_dat_i = 32'hDEAD_BEEF;
    for (int i = 0; i < int'(N); i++) begin
      m_adr_i[i*AW +: AW] = 32'h1000 * (i + 1);
      m_sel_i[i*SW +: SW] = 4'hF;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    tick();
    #2;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_scyc", 32'(s_cyc_o), 32'd0);
    chk("rst_ack", 32'(m_ack_o), 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] sel_tbl [3];
    sel_tbl = '{4'hF, 4'h3, 4'hC};

    // Test 1: single read by master 1, ACK two cycles after request.
    vt[0]  = '{4'b0010, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000};
    vt[1]  = '{4'b0010, 1'b0, 2'd1, 4'b0010, 1'b1, 4'b0000};
    vt[2]  = '{4'b0010, 1'b1, 2'd1, 4'b0010, 1'b1, 4'b0010};
    vt[3]  = '{4'b0000, 1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000};
    vt[4]  = '{4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000};
    vt[5]  = '{4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000};
    // Test 2: all four request together from reset, served 0,1,2,3.
    vt[6]  = '{4'b1111, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000};
    vt[7]  = '{4'b1111, 1'b1, 2'd1, 4'b0001, 1'b1, 4'b0001};
    vt[8]  = '{4'b1110, 1'b0, 2'd1, 4'b0001, 1'b0, 4'b0000};
    vt[9]  = '{4'b1110, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000};
    vt[10] = '{4'b1110, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000};
    vt[11] = '{4'b1110, 1'b1, 2'd1, 4'b0010, 1'b1, 4'b0010};
    vt[12] = '{4'b1100, 1'b0, 2'd1, 4'b0010, 1'b0, 4'b0000};
    vt[13] = '{4'b1100, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000};
    vt[14] = '{4'b1100, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000};
    vt[15] = '{4'b1100, 1'b1, 2'd1, 4'b0100, 1'b1, 4'b0100};
    vt[16] = '{4'b1000, 1'b0, 2'd1, 4'b0100, 1'b0, 4'b0000};
    vt[17] = '{4'b1000, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000};
    vt[18] = '{4'b1000, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000};
    vt[19] = '{4'b1000, 1'b1, 2'd1, 4'b1000, 1'b1, 4'b1000};
    vt[20] = '{4'b0000, 1'b0, 2'd1, 4'b1000, 1'b0, 4'b0000};
    vt[21] = '{4'b0000, 1'b0, 2'd2, 4'b0000, 1'b0, 4'b0000};
    vt[22] = '{4'b0000, 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000};

    reset = 1'b1;
    clear_inputs();
    do_reset();

    for (int i = 0; i < int'(NVEC); i++) begin
      if (i == int'(T2_START)) do_reset();
      tick();
      m_cyc_i = vt[i].cyc;
      m_stb_i = vt[i].cyc;
      s_ack_i = vt[i].ack;
      #2;
      chk($sformatf("v%0d_state", i), 32'(state_o), 32'(vt[i].st));
      chk($sformatf("v%0d_grant", i), 32'(grant_o), 32'(vt[i].gnt));
      chk($sformatf("v%0d_scyc", i), 32'(s_cyc_o), 32'(vt[i].scyc));
      chk($sformatf("v%0d_sstb", i), 32'(s_stb_o), 32'(vt[i].scyc));
      chk($sformatf("v%0d_ack", i), 32'(m_ack_o), 32'(vt[i].mack));
      chk($sformatf("v%0d_err", i), 32'(m_err_o), 32'd0);
      if (vt[i].ack) chk($sformatf("v%0d_rdata", i), m_dat_o, 32'hDEAD_BEEF);
    end

    // Test 3: master 1 locks the bus for three writes while master 0 waits. ptr is 0 here.
    tick();
    m_cyc_i = 4'b0010;
    #2;
    chk("t3_idle", 32'(state_o), 32'd0);
    for (int b = 0; b < 3; b++) begin
      tick();
      m_cyc_i = 4'b0011;
      m_stb_i = 4'b0011;
      m_we_i  = 4'b0010;
      m_adr_i[0*AW +: AW] = 32'hA00;
      m_adr_i[1*AW +: AW] = 32'h10 + 32'(4 * b);
      m_sel_i[1*SW +: SW] = sel_tbl[b];
      m_dat_i[1*DW +: DW] = 32'hCAFE_0000 + 32'(b);
      s_ack_i = 1'b1;
      #2;
      chk($sformatf("t3_b%0d_grant", b), 32'(grant_o), 32'b0010);
      chk($sformatf("t3_b%0d_stb", b), 32'(s_stb_o), 32'd1);
      chk($sformatf("t3_b%0d_we", b), 32'(s_we_o), 32'd1);
      chk($sformatf("t3_b%0d_adr", b), s_adr_o, 32'h10 + 32'(4 * b));
      chk($sformatf("t3_b%0d_sel", b), 32'(s_sel_o), 32'(sel_tbl[b]));
      chk($sformatf("t3_b%0d_dat", b), s_dat_o, 32'hCAFE_0000 + 32'(b));
      chk($sformatf("t3_b%0d_ack", b), 32'(m_ack_o), 32'b0010);
    end
    // Master 1 drops CYC; the slave keeps ACK high, which must not be forwarded.
    tick();
    m_cyc_i = 4'b0001;
    m_stb_i = 4'b0001;
    m_we_i  = 4'b0000;
    #2;
    chk("t3_drop_state", 32'(state_o), 32'd1);
    chk("t3_drop_scyc", 32'(s_cyc_o), 32'd0);
    chk("t3_drop_ack", 32'(m_ack_o), 32'd0);
    tick();
    #2;
    chk("t3_rel_state", 32'(state_o), 32'd2);
    chk("t3_rel_scyc", 32'(s_cyc_o), 32'd0);
    chk("t3_rel_ack", 32'(m_ack_o), 32'd0);
    tick();
    s_ack_i = 1'b0;
    #2;
    chk("t3_idle2_state", 32'(state_o), 32'd0);
    tick();
    #2;
    chk("t3_m0_grant", 32'(grant_o), 32'b0001);
    chk("t3_m0_adr", s_adr_o, 32'hA00);
    chk("t3_m0_we", 32'(s_we_o), 32'd0);
    tick();
    m_cyc_i = '0;
    m_stb_i = '0;
    tick();
    tick();
    #2;
    chk("t3_end_state", 32'(state_o), 32'd0);

    // Test 4: reset while master 2 owns the bus mid-beat. ptr is 1 here, so 2 wins alone.
    tick();
    m_cyc_i = 4'b0100;
    tick();
    m_stb_i = 4'b0100;
    #2;
    chk("t4_grant", 32'(grant_o), 32'b0100);
    chk("t4_scyc", 32'(s_cyc_o), 32'd1);
    tick();
    reset   = 1'b1;
    m_cyc_i = 4'b0101;
    m_stb_i = 4'b0101;
    s_ack_i = 1'b1;
    tick();
    #2;
    chk("t4_rst_scyc", 32'(s_cyc_o), 32'd0);
    chk("t4_rst_grant", 32'(grant_o), 32'd0);
    chk("t4_rst_state", 32'(state_o), 32'd0);
    chk("t4_rst_ack", 32'(m_ack_o), 32'd0);
    reset   = 1'b0;
    s_ack_i = 1'b0;
    // Masters 0 and 2 both pending: ptr=0 picks 0, a stale ptr of 1 would pick 2.
    tick();
    #2;
    chk("t4_ptr0_grant", 32'(grant_o), 32'b0001);
    tick();
    m_cyc_i = '0;
    m_stb_i = '0;
    tick();
    tick();
    #2;
    chk("t4_end_state", 32'(state_o), 32'd0);

    // Test 5: slave never ACKs master 1 (ptr is 1).
    tick();
    m_cyc_i = 4'b0010;
    tick();
    m_stb_i = 4'b0010;
`ifdef WB_ARB_TIMEOUT_EN
    for (int c = 0; c < int'(TMO); c++) begin
      if (c > 0) tick();
      #2;
      chk($sformatf("t5_stall%0d_err", c), 32'(m_err_o), 32'd0);
      chk($sformatf("t5_stall%0d_stb", c), 32'(s_stb_o), 32'd1);
    end
    tick();
    #2;
    chk("t5_err", 32'(m_err_o), 32'b0010);
    chk("t5_err_scyc", 32'(s_cyc_o), 32'd0);
    chk("t5_err_sstb", 32'(s_stb_o), 32'd0);
    tick();
    #2;
    chk("t5_rel_state", 32'(state_o), 32'd2);
    chk("t5_rel_grant", 32'(grant_o), 32'd0);
    chk("t5_rel_err", 32'(m_err_o), 32'd0);
`else
    for (int c = 0; c < 20; c++) begin
      if (c > 0) tick();
      #2;
      chk($sformatf("t5_hold%0d_err", c), 32'(m_err_o), 32'd0);
      chk($sformatf("t5_hold%0d_state", c), 32'(state_o), 32'd1);
    end
    chk("t5_hold_grant", 32'(grant_o), 32'b0010);
    chk("t5_hold_scyc", 32'(s_cyc_o), 32'd1);
`endif
    tick();
    m_cyc_i = '0;
    m_stb_i = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter.md
Name: wb_rr_arbiter

Overview:
- Round-robin arbiter that shares one Wishbone classic slave (STB/CYC/WE/ACK) among N masters.
- The slave sequencer sits downstream and sees a single master port.
- Grant is held for a whole CYC (bus lock), so a master can issue multiple STB beats back to back.
- A one-cycle turnaround follows every release so the slave FSM always returns to idle between owners.

Parameters:
- N, 4, number of masters (2..8).
- AW, 32, address width.
- DW, 32, data width (multiple of 8); SW = DW/8.
- TIMEOUT_CYCLES, 255, cycles without ACK before bus error (used only with the optional feature).

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- m_cyc_i  in  N  per-master CYC.
- m_stb_i  in  N  per-master STB.
- m_we_i  in  N  per-master WE.
- m_adr_i  in  N*AW  per-master address; master i occupies bits [i*AW +: AW].
- m_dat_i  in  N*DW  per-master write data, packed as for m_adr_i.
- m_sel_i  in  N*SW  per-master byte select, packed as for m_adr_i.
- m_dat_o  out  DW  read data, broadcast to all masters (= s_dat_i).
- m_ack_o  out  N  per-master ACK.
- m_err_o  out  N  per-master bus error.
- s_cyc_o, s_stb_o, s_we_o  out  1 each  to slave.
- s_adr_o  out  AW  to slave.
- s_dat_o  out  DW  to slave.
- s_sel_o  out  SW  to slave.
- s_dat_i  in  DW  from slave.
- s_ack_i  in  1  from slave.
- grant_o  out  N  one-hot registered grant; all zero when no owner.
- state_o  out  2  current arbiter state, for debug.

Behaviour:
- States and encoding: ARB_IDLE=0, ARB_BUSY=1, ARB_RELEASE=2.
- Reset: state ARB_IDLE, grant_o=0, priority pointer ptr=0, timeout counter 0. All slave outputs, m_ack_o and m_err_o are 0.
- Reset mid-transfer takes effect at the next clock edge, drops s_cyc_o the same cycle, and raises no ACK/ERR.
- ARB_IDLE:
  - If any m_cyc_i is high, select the first requester scanning ptr, ptr+1, ... modulo N.
  - Register the one-hot grant and go to ARB_BUSY. Arbitration latency is exactly one cycle: request at edge t, grant_o and s_cyc_o visible after edge t+1.
  - Otherwise remain in ARB_IDLE.
- ARB_BUSY, owner g:
  - s_cyc_o = m_cyc_i[g]; s_stb_o = m_cyc_i[g] & m_stb_i[g].
  - s_we_o, s_adr_o, s_dat_o and s_sel_o are the combinational mux of master g.
  - m_ack_o[g] = s_ack_i & s_stb_o. Every other m_ack_o bit is 0.
  - Non-owners never see ACK and are never preempted, regardless of their requests.
  - When m_cyc_i[g] falls: go to ARB_RELEASE, set ptr = (g+1) mod N, clear grant_o.
- ARB_RELEASE: lasts exactly one cycle with all slave outputs 0, then ARB_IDLE. Pending requests are arbitrated in ARB_IDLE with the updated ptr.
- Whenever there is no owner: s_we_o, s_adr_o, s_dat_o and s_sel_o are 0.
- Simultaneous requests resolve strictly by rotating priority. A master holding CYC continuously keeps the bus indefinitely unless the optional feature is enabled.
- A spurious s_ack_i while s_stb_o=0 is ignored and not forwarded.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- Defined: in ARB_BUSY a counter increments each cycle that s_stb_o=1 and s_ack_i=0, and clears on ACK or on leaving ARB_BUSY.
  - When the count reaches TIMEOUT_CYCLES, pulse m_err_o[g] for one cycle and force s_stb_o=0 and s_cyc_o=0 that cycle.
  - In the same cycle, move to ARB_RELEASE, revoke the grant and advance ptr, even if m_cyc_i[g] is still high.
- Undefined: m_err_o is tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset → state_o=0, grant_o=0, s_cyc_o=0; then m_cyc_i=0010 with one read beat, slave ACKs 2 cycles later with s_dat_i=0xDEADBEEF → grant_o=0010 one cycle after request, m_ack_o=0010 for one cycle, m_dat_o=0xDEADBEEF.
- All four masters request together from reset → grants in order 0001, 0010, 0100, 1000. Exactly one ARB_RELEASE cycle with s_cyc_o=0 separates each owner.
- Master 1 holds CYC for 3 write beats (adr 0x10, 0x14, 0x18) while master 0 requests → all 3 beats reach the slave with m_we_i, adr and sel intact. Master 0 is granted only after master 1 drops CYC, and m_ack_o[0] stays 0 throughout.
- Reset asserted mid-beat while master 2 is owner → next cycle s_cyc_o=0, grant_o=0, ptr=0, no ACK.
- WB_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, slave never ACKs → m_err_o[g] pulses after 8 stalled cycles and the bus goes to ARB_RELEASE. Undefined → m_err_o stays 0 and the owner keeps the bus.
